// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: line-locked round-robin sharing of one UART TX byte path
// UART_ARB_TAG_EN prefixes every granted line with "<owner>:"
module uart_tx_arbiter #(
    parameter int NumReq        = 4,
    parameter int TimeoutCycles = 4096
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NumReq-1:0]   req_valid_i,
    input  logic [NumReq*8-1:0] req_data_i,
    output logic [NumReq-1:0]   req_ready_o,
    output logic                tx_valid_o,
    output logic [7:0]          tx_data_o,
    input  logic                tx_ready_i,
    output logic [NumReq-1:0]   grant_o,
    output logic                busy_o
);
    localparam int IdxW = NumReq > 1 ? $clog2(NumReq) : 1;
    localparam int CntW = $clog2(TimeoutCycles + 1);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOCKED = 2'd1;
`ifdef UART_ARB_TAG_EN
    localparam logic [1:0] TAG    = 2'd2;
    localparam logic [1:0] START  = TAG;
`else
    localparam logic [1:0] START  = LOCKED;
`endif

    logic [1:0]        state;
    logic [IdxW-1:0]   owner, rr_ptr, pick, next_ptr;
    logic [CntW-1:0]   idle_cnt;
    logic [NumReq-1:0] owner_oh;
    logic [7:0]        owner_data, load_data;
    logic              can_load, accept, timeout, release_line, load;

    function automatic logic [IdxW-1:0] wrap(input logic [IdxW-1:0] base, input int k);
        int j;
        j = int'(base) + k;
        return IdxW'(j >= NumReq ? j - NumReq : j);
    endfunction

    always_comb begin
        pick = rr_ptr;
        for (int k = NumReq - 1; k >= 0; k--) begin
            if (req_valid_i[wrap(rr_ptr, k)]) pick = wrap(rr_ptr, k);
        end
    end

    assign owner_oh     = NumReq'(1) << owner;
    assign owner_data   = req_data_i[owner*8 +: 8];
    assign next_ptr     = owner == IdxW'(NumReq - 1) ? '0 : owner + IdxW'(1);
    assign can_load     = !tx_valid_o || tx_ready_i;
    assign req_ready_o  = (state == LOCKED && can_load) ? owner_oh : '0;
    assign accept       = |(req_ready_o & req_valid_i);
    assign timeout      = idle_cnt == CntW'(TimeoutCycles);
    assign release_line = state == LOCKED && ((accept && owner_data == 8'h0A) || timeout);
    assign grant_o      = state != IDLE ? owner_oh : '0;
    assign busy_o       = state != IDLE || tx_valid_o;

`ifdef UART_ARB_TAG_EN
    logic tag_cnt;
    logic tag_load;
    assign tag_load  = state == TAG && can_load;
    assign load      = accept || tag_load;
    assign load_data = accept ? owner_data : tag_cnt ? 8'h3A : 8'h30 + 8'(owner);
`else
    assign load      = accept;
    assign load_data = owner_data;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state      <= IDLE;
            owner      <= '0;
            rr_ptr     <= '0;
            idle_cnt   <= '0;
            tx_valid_o <= 1'b0;
            tx_data_o  <= 8'h00;
`ifdef UART_ARB_TAG_EN
            tag_cnt    <= 1'b0;
`endif
        end else begin
            tx_valid_o <= load || (tx_valid_o && !tx_ready_i);
            tx_data_o  <= load ? load_data : tx_data_o;
            idle_cnt   <= (state != LOCKED || accept) ? '0 :
                          (req_valid_i[owner] || timeout) ? idle_cnt : idle_cnt + CntW'(1);
            if (state == IDLE && |req_valid_i) begin
                owner <= pick;
                state <= START;
            end else if (release_line) begin
                rr_ptr <= next_ptr;
                state  <= IDLE;
            end
`ifdef UART_ARB_TAG_EN
            else if (tag_load) begin
                tag_cnt <= !tag_cnt;
                state   <= tag_cnt ? LOCKED : TAG;
            end
`endif
        end
    end
endmodule
